// File: rtl/burst_read_arbiter_pkg.sv
// Shared definitions for the burst read arbiter: burst length field width,
// elaboration-time log2 helper and the arbiter lock state encoding.
package burst_pkg;

   localparam int BURST_LEN_W = 8;

   // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // Width of an ID able to name n things, never narrower than one bit.
   function automatic int id_w(input int n);
      return (clog2(n) < 1) ? 1 : clog2(n);
   endfunction

   // Arbiter is either free to search or pinned to a stalled requester.
   typedef enum logic {
      ARB_OPEN   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/burst_read_arbiter_id_fifo.sv
// In-order FIFO of requester IDs, one entry per burst in flight. The head
// names the requester that owns the beats currently returning.
module burst_id_fifo
   import burst_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4,
   localparam int PTR_W = id_w(DEPTH),
   localparam int CNT_W = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Status flags, guarded push/pop and next pointer/count values.
   always_comb begin
      full     = (count_q == CNT_W'(DEPTH));
      empty    = (count_q == '0);
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Pointers and occupancy clear immediately on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/burst_read_arbiter.sv
// Round-robin arbiter sharing one burst read pipeline between NUM_REQ
// requesters. Commands pass through combinationally; return beats are steered
// back to their requester using an in-order FIFO of granted IDs.
module burst_read_arbiter
   import burst_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int OUTSTANDING = 4,
   localparam int ID_W  = id_w(NUM_REQ),
   localparam int CNT_W = clog2(OUTSTANDING) + 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  r_addr,
   input  logic [NUM_REQ*BURST_LEN_W-1:0] r_length,
   input  logic [NUM_REQ-1:0]             r_valid,
   output logic [NUM_REQ-1:0]             r_ready,
   output logic [ADDR_WIDTH-1:0]          p_addr,
   output logic [BURST_LEN_W-1:0]         p_length,
   output logic                           p_valid,
   input  logic                           p_ready,
   input  logic [DATA_WIDTH-1:0]          p_data,
   input  logic                           p_rvalid,
   input  logic                           p_rlast,
   output logic                           p_rready,
   output logic [DATA_WIDTH-1:0]          q_data,
   output logic [NUM_REQ-1:0]             q_valid,
   output logic                           q_last,
   input  logic [NUM_REQ-1:0]             q_ready,
   output logic [CNT_W-1:0]               outstanding
);

   arb_state_e      state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] lock_id_q, lock_id_d;
   logic [ID_W-1:0] pick, grant, head;
   logic            fifo_full, fifo_empty;
   logic            accept, pop, head_ready;

   // First requesting index at or after start, wrapping at NUM_REQ.
   function automatic logic [ID_W-1:0] rr_search(input logic [NUM_REQ-1:0] req,
                                                 input logic [ID_W-1:0]    start);
      logic [2*NUM_REQ-1:0] rot;
      logic [ID_W-1:0]      win;
      int                   pos;
      rot = {req, req} >> start;
      win = start;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            pos = int'(start) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            win = ID_W'(pos);
         end
      end
      return win;
   endfunction

   // Command side: pick the winner, mux its command, acknowledge on accept.
   always_comb begin
      pick     = rr_search(r_valid, rr_ptr_q);
      grant    = (state_q == ARB_LOCKED) ? lock_id_q : pick;
      // rst_n gates p_valid so a held request cannot leak out during reset.
      p_valid  = rst_n & ~fifo_full & ((state_q == ARB_LOCKED) | (|r_valid));
      accept   = p_valid & p_ready;
      p_addr   = '0;
      p_length = '0;
      r_ready  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            p_addr     = r_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            p_length   = r_length[i*BURST_LEN_W +: BURST_LEN_W];
            r_ready[i] = accept;
         end
      end
   end

   // Return side: route beats to the FIFO head and honour its backpressure.
   always_comb begin
      q_valid    = '0;
      head_ready = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (head == ID_W'(i)) begin
            q_valid[i] = p_rvalid & ~fifo_empty;
            head_ready = q_ready[i];
         end
      end
      p_rready = ~fifo_empty & head_ready;
      pop      = p_rvalid & p_rready & p_rlast;
      q_data   = p_data;
      q_last   = p_rlast;
   end

   // Next arbiter state: accept advances the pointer and unlocks, a stall locks.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      lock_id_d = lock_id_q;
      if (accept) begin
         state_d  = ARB_OPEN;
         rr_ptr_d = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      end else if (p_valid) begin
         state_d   = ARB_LOCKED;
         lock_id_d = grant;
      end
   end

   // Arbiter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARB_OPEN;
         rr_ptr_q  <= '0;
         lock_id_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         lock_id_q <= lock_id_d;
      end
   end

   burst_id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (OUTSTANDING)
   ) u_id_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .pop   (pop),
      .din   (grant),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (outstanding)
   );

   // A beat with nothing outstanding has no owner and is never accepted.
   assert property (@(posedge clk) disable iff (!rst_n) !(p_rvalid && fifo_empty));

endmodule

// File: tb/tb_burst_read_arbiter.sv
// Randomised bench for burst_read_arbiter with a queue-based reference model
// and a pipeline emulator that returns data = address + beat index.
module tb_burst_read_arbiter;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int OUT = 4;
   localparam int OW  = $clog2(OUT) + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N*AW-1:0] r_addr = '0;
   logic [N*8-1:0]  r_length = '0;
   logic [N-1:0]    r_valid = '0;
   logic [N-1:0]    r_ready;
   logic [AW-1:0]   p_addr;
   logic [7:0]      p_length;
   logic            p_valid;
   logic            p_ready = 1'b0;
   logic [DW-1:0]   p_data = '0;
   logic            p_rvalid = 1'b0;
   logic            p_rlast = 1'b0;
   logic            p_rready;
   logic [DW-1:0]   q_data;
   logic [N-1:0]    q_valid;
   logic            q_last;
   logic [N-1:0]    q_ready = '0;
   logic [OW-1:0]   outstanding;

   always #5 clk = ~clk;

   burst_read_arbiter #(
      .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTSTANDING(OUT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .r_addr(r_addr), .r_length(r_length), .r_valid(r_valid), .r_ready(r_ready),
      .p_addr(p_addr), .p_length(p_length), .p_valid(p_valid), .p_ready(p_ready),
      .p_data(p_data), .p_rvalid(p_rvalid), .p_rlast(p_rlast), .p_rready(p_rready),
      .q_data(q_data), .q_valid(q_valid), .q_last(q_last), .q_ready(q_ready),
      .outstanding(outstanding)
   );

   int nvec = 0;
   int nerr = 0;

   // requester commands held by the bench until accepted
   bit            pend [N];
   logic [AW-1:0] c_addr [N];
   logic [7:0]    c_len [N];

   // reference model: rotation pointer, lock, and queue of owners in flight
   int rr = 0;
   bit locked = 0;
   int lock_id = 0;
   int mq[$];

   // pipeline emulator: accepted commands and current beat
   logic [AW-1:0] pq_addr[$];
   int            pq_len[$];
   int            beat = 0;
   bit            rv_hold = 0;

   int req_rate = 0, pr_rate = 100, rv_rate = 100, qr_rate = 100, max_len = 0;

   // observations for directed expectations
   int            obs_grant[$];
   int            obs_owner[$];
   logic [DW-1:0] obs_data[$];
   bit            obs_last[$];
   logic          last_pvalid, last_prready;
   logic [N-1:0]  last_rready, last_qvalid;
   logic [AW-1:0] last_paddr;
   logic [DW-1:0] last_qdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int oh2i(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic set_cmd(input int i, input logic [AW-1:0] a, input logic [7:0] l);
      pend[i]   = 1;
      c_addr[i] = a;
      c_len[i]  = l;
   endtask

   task automatic clear_obs();
      obs_grant.delete(); obs_owner.delete(); obs_data.delete(); obs_last.delete();
   endtask

   task automatic clear_model();
      rr = 0; locked = 0; lock_id = 0; mq.delete();
      pq_addr.delete(); pq_len.delete(); beat = 0; rv_hold = 0;
      for (int i = 0; i < N; i++) pend[i] = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && $urandom_range(99) < req_rate) begin
            set_cmd(i, $urandom, 8'($urandom_range(max_len)));
         end
         r_valid[i]          = pend[i];
         r_addr[i*AW +: AW]  = c_addr[i];
         r_length[i*8 +: 8]  = c_len[i];
      end
      p_ready = ($urandom_range(99) < pr_rate);
      for (int i = 0; i < N; i++) q_ready[i] = ($urandom_range(99) < qr_rate);
      if (pq_addr.size() > 0 && (rv_hold || $urandom_range(99) < rv_rate)) begin
         p_rvalid = 1'b1;
         p_data   = pq_addr[0] + DW'(beat);
         p_rlast  = (beat == pq_len[0]);
      end else begin
         p_rvalid = 1'b0;
         p_data   = $urandom;
         p_rlast  = 1'($urandom);
      end
   endtask

   // One clock: drive at negedge, compare 1 time unit later, update at posedge.
   task automatic step();
      int g, h;
      bit found, busy, e_pv, acc, e_prr, beat_ok;
      logic [N-1:0] e_rr, e_qv;
      drive();
      #1;
      busy  = (mq.size() >= OUT);
      g     = 0;
      found = 0;
      if (locked) g = lock_id;
      else begin
         for (int k = 0; k < N; k++) begin
            if (!found && r_valid[(rr + k) % N]) begin
               g = (rr + k) % N;
               found = 1;
            end
         end
      end
      e_pv  = !busy && (locked || found);
      acc   = e_pv && p_ready;
      e_rr  = acc ? (N'(1) << g) : '0;
      h     = (mq.size() > 0) ? mq[0] : 0;
      e_qv  = (p_rvalid && mq.size() > 0) ? (N'(1) << h) : '0;
      e_prr = (mq.size() > 0) && q_ready[h];
      chk("p_valid", 64'(p_valid), 64'(e_pv));
      if (e_pv) begin
         chk("p_addr", 64'(p_addr), 64'(c_addr[g]));
         chk("p_length", 64'(p_length), 64'(c_len[g]));
      end
      chk("r_ready", 64'(r_ready), 64'(e_rr));
      chk("q_valid", 64'(q_valid), 64'(e_qv));
      chk("p_rready", 64'(p_rready), 64'(e_prr));
      if (e_qv != '0) begin
         chk("q_data", 64'(q_data), 64'(p_data));
         chk("q_last", 64'(q_last), 64'(p_rlast));
      end
      chk("outstanding", 64'(outstanding), 64'(mq.size()));
      last_pvalid  = p_valid;
      last_prready = p_rready;
      last_rready  = r_ready;
      last_qvalid  = q_valid;
      last_paddr   = p_addr;
      last_qdata   = q_data;
      if (r_ready != '0) obs_grant.push_back(oh2i(r_ready));
      if (p_rvalid && p_rready) begin
         obs_owner.push_back(oh2i(q_valid));
         obs_data.push_back(q_data);
         obs_last.push_back(q_last);
      end
      beat_ok = p_rvalid && e_prr;
      @(posedge clk);
      if (acc) begin
         mq.push_back(g);
         pq_addr.push_back(c_addr[g]);
         pq_len.push_back(int'(c_len[g]));
         pend[g] = 0;
         rr      = (g + 1) % N;
         locked  = 0;
      end else if (e_pv) begin
         locked  = 1;
         lock_id = g;
      end
      if (beat_ok) begin
         rv_hold = 0;
         if (p_rlast) begin
            void'(mq.pop_front());
            void'(pq_addr.pop_front());
            void'(pq_len.pop_front());
            beat = 0;
         end else begin
            beat++;
         end
      end else if (p_rvalid) begin
         rv_hold = 1;
      end
      @(negedge clk);
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, " p_valid"}, 64'(p_valid), 64'd0);
      chk({tag, " r_ready"}, 64'(r_ready), 64'd0);
      chk({tag, " q_valid"}, 64'(q_valid), 64'd0);
      chk({tag, " p_rready"}, 64'(p_rready), 64'd0);
      chk({tag, " outstanding"}, 64'(outstanding), 64'd0);
   endtask

   // Reset with busy-looking inputs to show outputs are forced quiet.
   task automatic reset_all();
      rst_n = 1'b0;
      clear_model();
      r_valid = '1; p_ready = 1'b1; p_rvalid = 1'b1; p_rlast = 1'b1; q_ready = '1;
      @(negedge clk);
      #1;
      check_quiet("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // single requester 1, addr 0x100, length-1 = 3
      reset_all();
      req_rate = 0; pr_rate = 100; rv_rate = 100; qr_rate = 100;
      clear_obs();
      set_cmd(1, 32'h100, 8'd3);
      for (int c = 0; c < 10; c++) step();
      chk("t1 grants", 64'(obs_grant.size()), 64'd1);
      chk("t1 grant id", 64'(obs_grant[0]), 64'd1);
      chk("t1 beats", 64'(obs_owner.size()), 64'd4);
      for (int k = 0; k < 4 && k < obs_owner.size(); k++) begin
         chk("t1 owner", 64'(obs_owner[k]), 64'd1);
         chk("t1 data", 64'(obs_data[k]), 64'(32'h100 + k));
         chk("t1 last", 64'(obs_last[k]), 64'(k == 3));
      end
      chk("t1 outstanding", 64'(outstanding), 64'd0);

      // all requesters continuously valid with single-beat bursts
      reset_all();
      req_rate = 100; max_len = 0;
      clear_obs();
      for (int c = 0; c < 12; c++) step();
      chk("t2 grant count", 64'(obs_grant.size() >= 8), 64'd1);
      chk("t2 return count", 64'(obs_owner.size() >= 8), 64'd1);
      for (int k = 0; k < 8 && k < obs_grant.size() && k < obs_owner.size(); k++) begin
         chk("t2 grant order", 64'(obs_grant[k]), 64'(k % 4));
         chk("t2 return order", 64'(obs_owner[k]), 64'(k % 4));
      end

      // lock: requester 2 stalled, requester 0 appears meanwhile
      reset_all();
      req_rate = 0; pr_rate = 0;
      clear_obs();
      set_cmd(2, 32'hA200, 8'd1);
      step();
      chk("lock p_valid", 64'(last_pvalid), 64'd1);
      chk("lock addr0", 64'(last_paddr), 64'hA200);
      set_cmd(0, 32'hA000, 8'd0);
      for (int c = 0; c < 2; c++) begin
         step();
         chk("lock addr held", 64'(last_paddr), 64'hA200);
         chk("lock no ready", 64'(last_rready), 64'd0);
      end
      set_cmd(3, 32'hA300, 8'd0);
      pr_rate = 100;
      for (int c = 0; c < 3; c++) step();
      chk("lock grants", 64'(obs_grant.size()), 64'd3);
      chk("lock grant a", 64'(obs_grant[0]), 64'd2);
      chk("lock grant b", 64'(obs_grant[1]), 64'd3);
      chk("lock grant c", 64'(obs_grant[2]), 64'd0);
      for (int c = 0; c < 8; c++) step();

      // fill to OUTSTANDING with no returns
      reset_all();
      req_rate = 100; max_len = 0; pr_rate = 100; rv_rate = 0; qr_rate = 100;
      for (int c = 0; c < 6; c++) step();
      chk("full outstanding", 64'(outstanding), 64'd4);
      chk("full p_valid", 64'(last_pvalid), 64'd0);
      rv_rate = 100;
      step();
      chk("full pop cycle p_valid", 64'(last_pvalid), 64'd0);
      chk("full pop accepted", 64'(last_prready), 64'd1);
      rv_rate = 0;
      step();
      chk("full reissue p_valid", 64'(last_pvalid), 64'd1);
      chk("full reissue grant", 64'(last_rready), 64'd1);
      chk("full refilled", 64'(outstanding), 64'd4);

      // return backpressure mid-burst
      reset_all();
      req_rate = 0; pr_rate = 100; rv_rate = 100; qr_rate = 100;
      clear_obs();
      set_cmd(1, 32'h200, 8'd3);
      for (int c = 0; c < 3; c++) step();
      qr_rate = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("bp q_valid", 64'(last_qvalid), 64'b0010);
         chk("bp p_rready", 64'(last_prready), 64'd0);
         chk("bp data held", 64'(last_qdata), 64'h202);
      end
      qr_rate = 100;
      for (int c = 0; c < 3; c++) step();
      chk("bp beats", 64'(obs_data.size()), 64'd4);
      chk("bp final data", 64'(obs_data[obs_data.size() - 1]), 64'h203);

      // asynchronous reset with two bursts in flight, one mid-burst
      reset_all();
      req_rate = 0; pr_rate = 100; rv_rate = 0; qr_rate = 100;
      set_cmd(0, 32'h300, 8'd3);
      set_cmd(1, 32'h400, 8'd3);
      for (int c = 0; c < 2; c++) step();
      chk("ar outstanding", 64'(outstanding), 64'd2);
      rv_rate = 100;
      step();
      r_valid = '1; p_ready = 1'b1; p_rvalid = 1'b1; q_ready = '1;
      #2;
      rst_n = 1'b0;
      #1;
      check_quiet("async");
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      clear_obs();
      rv_rate = 0;
      for (int i = 0; i < N; i++) set_cmd(i, 32'h500 + 32'(i), 8'd0);
      step();
      chk("ar restart grant", 64'(obs_grant.size() > 0 ? obs_grant[0] : -1), 64'd0);

      // randomised traffic
      reset_all();
      for (int seg = 0; seg < 40; seg++) begin
         req_rate = $urandom_range(100, 10);
         pr_rate  = $urandom_range(100, 20);
         rv_rate  = $urandom_range(100, 20);
         qr_rate  = $urandom_range(100, 20);
         max_len  = $urandom_range(5);
         for (int c = 0; c < 100; c++) step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
